// File: rtl/mdu_pkg.sv
// Shared types and constants for the M-extension issue controller.
// Optional feature macro used by the top: MDU_DIVZERO_FAST_EN.
package mdu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mdu_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // RISC-V quotient for a zero divisor
  localparam logic [31:0] DIVZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_issue_ctrl_op_decode.sv
// funct3 decode: selects the target unit and the 2-bit operation type.
module mdu_op_decode
  import mdu_pkg::*;
(
  input  logic [2:0] funct3,
  output logic       is_div,
  output logic [1:0] unit_type
);

  assign is_div    = (funct3 == F3_DIV) || (funct3 == F3_DIVU) ||
                     (funct3 == F3_REM) || (funct3 == F3_REMU);
  assign unit_type = funct3[1:0];

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue controller between the CPU and separate multiplier / divider units.
// Optional: MDU_DIVZERO_FAST_EN answers divide-by-zero without the divider.
module mdu_issue_ctrl
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  unit_type,
  output logic [31:0] unit_op_a,
  output logic [31:0] unit_op_b,
  output logic        mul_in_valid,
  input  logic [31:0] mul_out,
  input  logic        mul_out_valid,
  input  logic        mul_busy,
  output logic        mul_cpu_busy,
  output logic        div_in_valid,
  input  logic [31:0] div_out,
  input  logic        div_out_valid,
  input  logic        div_busy,
  output logic        div_cpu_busy,
  output mdu_state_e  dbg_state
);

  // Handshakes (req_*, rsp_*): a transfer happens on a rising edge where
  // valid and ready are both high; the sender holds valid and payload until then.

  mdu_state_e  state_q, state_d;
  logic        div_q;
  logic [1:0]  type_q;
  logic [31:0] op_a_q, op_b_q, rsp_data_q;
  logic        dec_div;
  logic [1:0]  dec_type;
  logic        accept, fast_zero;
  logic        tgt_busy, tgt_out_valid;
  logic [31:0] tgt_out;
  logic        cpu_busy;

  mdu_op_decode u_op_decode (
    .funct3    (req_funct3),
    .is_div    (dec_div),
    .unit_type (dec_type)
  );

  assign accept = req_valid && (state_q == ST_IDLE);

`ifdef MDU_DIVZERO_FAST_EN
  assign fast_zero = dec_div && (req_rs2 == 32'd0);
`else
  assign fast_zero = 1'b0;
`endif

  assign tgt_busy      = div_q ? div_busy      : mul_busy;
  assign tgt_out_valid = div_q ? div_out_valid : mul_out_valid;
  assign tgt_out       = div_q ? div_out       : mul_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= 1'b0;
      type_q     <= 2'b00;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      rsp_data_q <= 32'd0;
    end else begin
      if (accept) begin
        div_q  <= dec_div;
        type_q <= dec_type;
        op_a_q <= req_rs1;
        op_b_q <= req_rs2;
      end
      // REM/REMU (type[1]=1) return the dividend on a zero divisor
      if (accept && fast_zero) begin
        rsp_data_q <= dec_type[1] ? req_rs1 : DIVZERO_QUOT;
      end else if ((state_q == ST_WAIT) && tgt_out_valid) begin
        rsp_data_q <= tgt_out;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    mul_in_valid = 1'b0;
    div_in_valid = 1'b0;
    cpu_busy     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = fast_zero ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!tgt_busy) begin
          mul_in_valid = !div_q;
          div_in_valid = div_q;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cpu_busy = 1'b0;
        if (tgt_out_valid) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_data     = rsp_data_q;
  assign unit_type    = type_q;
  assign unit_op_a    = op_a_q;
  assign unit_op_b    = op_b_q;
  assign mul_cpu_busy = cpu_busy;
  assign div_cpu_busy = cpu_busy;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl with behavioural multiplier/divider models.
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

  localparam int MUL_LAT = 19;
  localparam int DIV_LAT = 34;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  unit_type;
  logic [31:0] unit_op_a, unit_op_b;
  logic        mul_in_valid, mul_out_valid, mul_busy, mul_cpu_busy;
  logic [31:0] mul_out;
  logic        div_in_valid, div_out_valid, div_busy, div_cpu_busy;
  logic [31:0] div_out;
  mdu_state_e  dbg_state;
  logic        mul_busy_force;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int mul_pulses = 0;
  int div_pulses = 0;

  mdu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .unit_type(unit_type), .unit_op_a(unit_op_a), .unit_op_b(unit_op_b),
    .mul_in_valid(mul_in_valid), .mul_out(mul_out), .mul_out_valid(mul_out_valid),
    .mul_busy(mul_busy), .mul_cpu_busy(mul_cpu_busy),
    .div_in_valid(div_in_valid), .div_out(div_out), .div_out_valid(div_out_valid),
    .div_busy(div_busy), .div_cpu_busy(div_cpu_busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] up;
    logic signed [31:0] sa, sb, sr;
    sa = a;
    sb = b;
    case (f3)
      F3_MUL:    begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      F3_MULH:   begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      F3_MULHSU: begin up = {{32{a[31]}}, a} * {32'd0, b}; return up[63:32]; end
      F3_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sr = sa / sb;
        return sr;
      end
      F3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sr = sa % sb;
        return sr;
      end
      F3_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic is_fast(input logic [2:0] f3, input logic [31:0] b);
`ifdef MDU_DIVZERO_FAST_EN
    return f3[2] && (b == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Cycles from the acceptance cycle to the first cycle with rsp_valid, idle units
  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] b);
    if (is_fast(f3, b)) return 1;
    return f3[2] ? DIV_LAT + 2 : MUL_LAT + 2;
  endfunction

  // ---------------- unit models ----------------
  logic m_busy, m_ov, d_busy, d_ov;
  logic [31:0] m_res, d_res;
  int m_cnt, d_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_ov <= 1'b0; m_res <= 32'd0; m_cnt <= 0;
    end else if (mul_in_valid) begin
      m_busy <= 1'b1; m_ov <= 1'b0; m_cnt <= 1;
      m_res  <= ref_mdu({1'b0, unit_type}, unit_op_a, unit_op_b);
    end else if (m_ov) begin
      if (!mul_cpu_busy) begin m_ov <= 1'b0; m_busy <= 1'b0; end
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == MUL_LAT) m_ov <= 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_busy <= 1'b0; d_ov <= 1'b0; d_res <= 32'd0; d_cnt <= 0;
    end else if (div_in_valid) begin
      d_busy <= 1'b1; d_ov <= 1'b0; d_cnt <= 1;
      d_res  <= ref_mdu({1'b1, unit_type}, unit_op_a, unit_op_b);
    end else if (d_ov) begin
      if (!div_cpu_busy) begin d_ov <= 1'b0; d_busy <= 1'b0; end
    end else if (d_busy) begin
      d_cnt <= d_cnt + 1;
      if (d_cnt + 1 == DIV_LAT) d_ov <= 1'b1;
    end
  end

  assign mul_busy      = m_busy | mul_busy_force;
  assign mul_out_valid = m_ov;
  assign mul_out       = m_res;
  assign div_busy      = d_busy;
  assign div_out_valid = d_ov;
  assign div_out       = d_res;

  always @(posedge clk) begin
    if (mul_in_valid) mul_pulses <= mul_pulses + 1;
    if (div_in_valid) div_pulses <= div_pulses + 1;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_unit_type"}, {30'd0, unit_type}, 32'd0);
    check({tag, "_unit_op_a"}, unit_op_a, 32'd0);
    check({tag, "_unit_op_b"}, unit_op_b, 32'd0);
    check({tag, "_in_valids"}, {30'd0, mul_in_valid, div_in_valid}, 32'd0);
    check({tag, "_cpu_busy"}, {30'd0, mul_cpu_busy, div_cpu_busy}, 32'd3);
  endtask

  // ---------------- driver ----------------
  // Called and returns at a negedge. One full request/response transaction.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int hold);
    int w, lat, mp0, dp0;
    logic [31:0] held;
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b;
    w = 0;
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    if (!req_ready) begin
      check("accept_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    mp0 = mul_pulses; dp0 = div_pulses;
    @(negedge clk);
    req_valid = 1'b0;
    req_rs1 = $urandom; req_rs2 = $urandom; req_funct3 = 3'($urandom_range(0, 7));
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    check("latency", lat, exp_latency(f3, b));
    check("rsp_data", rsp_data, exp_q.pop_front());
    check("unit_type", {30'd0, unit_type}, {30'd0, f3[1:0]});
    check("unit_op_a", unit_op_a, a);
    check("unit_op_b", unit_op_b, b);
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_data", rsp_data, held);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    check("mul_pulses", mul_pulses - mp0, (!f3[2]) ? 32'd1 : 32'd0);
    check("div_pulses", div_pulses - dp0, (f3[2] && !is_fast(f3, b)) ? 32'd1 : 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int mp0, w, seen;
    logic [2:0] f3;
    logic [31:0] a, b;

    vecs[0]  = '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10};
    vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0};
    vecs[2]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0};
    vecs[3]  = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0};
    vecs[4]  = '{F3_DIV,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 2};
    vecs[5]  = '{F3_DIVU,   32'd100,       32'd7,         32'd14,        0};
    vecs[6]  = '{F3_REM,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 0};
    vecs[7]  = '{F3_REMU,   32'd100,       32'd7,         32'd2,         0};
    vecs[8]  = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
    vecs[9]  = '{F3_DIVU,   32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 3};
    vecs[10] = '{F3_REM,    32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 0};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; mul_busy_force = 1'b0;
    req_funct3 = 3'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven directed vectors
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);
    end

    // Multiplier busy at acceptance: start pulse must wait, then fire once
    mul_busy_force = 1'b1;
    mp0 = mul_pulses;
    req_valid = 1'b1; req_funct3 = F3_MUL; req_rs1 = 32'd3; req_rs2 = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("busy_hold_in_valid", {31'd0, mul_in_valid}, 32'd0);
      @(negedge clk);
    end
    check("busy_hold_state", {30'd0, dbg_state}, {30'd0, ST_ISSUE});
    mul_busy_force = 1'b0;
    w = 0;
    while (!rsp_valid && w < 100) begin @(negedge clk); w++; end
    check("busy_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("busy_rsp_data", rsp_data, 32'd15);
    check("busy_pulse_once", mul_pulses - mp0, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset while waiting on the divider: result discarded, next op clean
    req_valid = 1'b1; req_funct3 = F3_DIVU; req_rs1 = 32'd1000; req_rs2 = 32'd10;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_state", {30'd0, dbg_state}, {30'd0, ST_WAIT});
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("post_reset_no_rsp", seen, 32'd0);
    do_op(F3_MUL, 32'd12, 32'd11, 32'd132, 0);

    // Randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'h0000_0001;
        default: b = $urandom;
      endcase
      do_op(f3, a, b, ref_mdu(f3, a, b), $urandom_range(0, 3));
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
